uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- Serial-side bus initiator for the 6502 system: consumes the byte stream from the UART receiver and turns host commands into RAM write/read cycles.
- Returns read data and status bytes to the UART transmitter.
- Can hold the CPU in reset while memory is loaded.
- Sits on the clk25 domain beside the RAM interleave. It occupies the CPU memory slot only while cpu_hold is high; the system muxes it in when held.

Parameters:
- TIMEOUT_CYC, 2500000, clk25 cycles of rx inactivity inside a partial frame before abort (about 100 ms).
- HOLD_ON_RESET, 0, reset value of cpu_hold.

Ports:
- clk25  input  1  main clock
- rst  input  1  reset; asynchronous, active-high
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte
- tx_ready  input  1  transmitter can accept a byte
- tx_valid  output  1  byte offered to transmitter
- tx_data  output  8  byte to transmit
- mem_req  output  1  memory cycle request
- mem_we  output  1  1 = write, 0 = read; stable while mem_req is high
- mem_addr  output  16  memory address
- mem_wdata  output  8  write data
- mem_ack  input  1  cycle complete; mem_rdata is valid in this cycle
- mem_rdata  input  8  read data
- cpu_hold  output  1  holds the CPU in reset / grants the memory slot to the loader
- busy  output  1  high in every state except IDLE
- err  output  1  one-cycle error pulse

Behaviour:
- Reset values: tx_valid=0, tx_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err=0, cpu_hold=HOLD_ON_RESET; state=IDLE.
- Commands (first byte of a frame):
  - 0x57 'W': then addr_hi, addr_lo, len, then len data bytes.
  - 0x52 'R': then addr_hi, addr_lo, len.
  - 0x48 'H': set cpu_hold=1.
  - 0x47 'G': clear cpu_hold=0.
- len: 8 bits, 0 means 256. Internal count is 9 bits.
- Command legality:
  - W and R are legal only while cpu_hold=1.
  - W or R with cpu_hold=0 -> err pulse, reply 0x3F, back to IDLE. The remaining bytes of that frame are parsed as new commands.
  - Unknown command byte -> err pulse, reply 0x3F.
  - H and G reply 0x4B 'K'.
- States: IDLE, ADDR_H, ADDR_L, LEN, DATA, WR, RD, RSEND, REPLY.
  - IDLE -> ADDR_H on W/R. H/G/unknown -> REPLY.
  - ADDR_H -> ADDR_L -> LEN, each on rx_valid.
  - LEN -> DATA for W, -> RD for R.
  - DATA: on rx_valid, latch byte into mem_wdata, go to WR.
  - WR: mem_req=1, mem_we=1 until mem_ack. On ack: mem_addr+1 and count-1. Then count==0 -> REPLY(0x4B), else -> DATA.
  - RD: mem_req=1, mem_we=0. On ack: latch mem_rdata into tx_data, go to RSEND.
  - RSEND: tx_valid=1 until the cycle with tx_ready=1. Then mem_addr+1, count-1. Then count==0 -> IDLE, else -> RD.
  - REPLY: tx_valid=1 with the reply byte until tx_ready=1, then -> IDLE.
- Latency:
  - mem_req rises the cycle after the triggering rx_valid (W) or LEN byte (R).
  - mem_req falls the cycle after mem_ack.
  - tx_valid rises the cycle after mem_ack.
  - Single-cycle ack: mem_ack may be high in the same cycle mem_req first asserts; the ack is honoured.
- Address arithmetic: 16-bit wrap, 0xFFFF+1 = 0x0000. A frame may span the wrap.
- Dropped bytes: rx_valid in WR, RD, RSEND or REPLY -> byte dropped, err pulse, state unchanged.
- Timeout:
  - Counter clears on every accepted byte and runs in ADDR_H, ADDR_L, LEN and DATA.
  - Reaching TIMEOUT_CYC -> err pulse, IDLE, no reply.
  - The counter does not run while waiting on mem_ack or tx_ready.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). mem_req drops even without ack. cpu_hold returns to HOLD_ON_RESET.
- Simultaneous events: if rx_valid coincides with timeout expiry, the byte wins and the counter clears.
- cpu_hold changes only in the REPLY entry of H/G, so it never toggles while mem_req=1.

Decomposition:
- Shared package/constants file: command codes (0x57, 0x52, 0x48, 0x47), reply codes (0x4B, 0x3F) and state encoding. The host-side tools use the same codes.
- One sub-module is natural: loader_timeout (counter with clear/enable, expiry strobe), parameterised by TIMEOUT_CYC.

Test Plan:
- Reset with HOLD_ON_RESET=1 -> cpu_hold=1, busy=0, tx_valid=0. Send 0x47 -> tx_data=0x4B, then cpu_hold=0.
- Hold set; send 57 12 34 03 AA BB CC, mem_ack one cycle after each req -> writes 0x1234=AA, 0x1235=BB, 0x1236=CC; reply 0x4B. Repeat with ack in the same cycle as req -> identical result.
- Send 52 FF FF 02, model returns 0x11 at 0xFFFF and 0x22 at 0x0000, tx_ready stalls 5 cycles per byte -> tx sequence 11 22, mem_addr wraps to 0x0000, no err.
- Send 57 00 00 00 followed by 256 data bytes -> 256 writes to 0x0000-0x00FF, one 0x4B reply.
- Send 0x57 with cpu_hold=0 -> err pulse, reply 0x3F, no mem_req. Send 0x99 -> err, reply 0x3F.
- TIMEOUT_CYC=100: send 57 10, then idle 100 cycles -> err pulse, busy=0. Assert rst while mem_req=1 -> mem_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared command/reply codes and state encoding for the UART memory loader.
// The host-side tools use the same byte codes.
package uart_mem_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_HOLD  = 8'h48;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] RPL_OK    = 8'h4B;
    localparam logic [7:0] RPL_ERR   = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_DATA,
        ST_WR,
        ST_RD,
        ST_RSEND,
        ST_REPLY
    } loader_state_t;

    // A length byte of zero stands for a full 256-byte block.
    function automatic logic [8:0] lenToCount(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// UART byte stream and memory bus seen by the loader; master is the loader,
// slave is the UART/RAM side.
interface uart_mem_loader_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       mem_req;
    logic       mem_we;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
        output tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
        input  tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/uart_mem_loader_timeout.sv
// Inactivity counter for partially received frames; o_expire strobes once
// TIMEOUT_CYC enabled cycles pass without a clear.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic clk25,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_count;

    assign o_expire = i_enable && (r_count == CW'(TIMEOUT_CYC - 1));

    // Held at zero outside the frame-parsing states so each frame starts fresh.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else if (!o_expire) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial-side bus initiator: parses host command frames from the UART and
// performs RAM write/read cycles while the CPU is held off the memory slot.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC   = 2500000,
    parameter bit HOLD_ON_RESET = 1'b0
) (
    input  logic clk25,
    input  logic rst,
    uart_mem_loader_if.master bus,
    output logic cpu_hold,
    output logic busy,
    output logic err
);

    loader_state_t r_state;
    loader_state_t w_stateNext;

    logic        r_isWrite;
    logic [15:0] r_addr;
    logic [8:0]  r_count;
    logic [7:0]  r_wdata;
    logic [7:0]  r_txData;
    logic        r_err;
    logic        r_cpuHold;

    logic        w_errNext;
    logic        w_replyLoad;
    logic [7:0]  w_replyCode;
    logic        w_holdSet;
    logic        w_holdClr;
    logic        w_timerEn;
    logic        w_expire;

    assign w_timerEn = (r_state == ST_ADDR_H) || (r_state == ST_ADDR_L) ||
                       (r_state == ST_LEN)    || (r_state == ST_DATA);

    loader_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk25   (clk25),
        .rst     (rst),
        .i_clear (bus.rx_valid),
        .i_enable(w_timerEn),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_stateNext;
    end

    // A received byte always takes priority over a coincident timeout.
    always_comb begin
        w_stateNext = r_state;
        w_errNext   = 1'b0;
        w_replyLoad = 1'b0;
        w_replyCode = RPL_OK;
        w_holdSet   = 1'b0;
        w_holdClr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    w_stateNext = ST_REPLY;
                    w_replyLoad = 1'b1;
                    case (bus.rx_data)
                        CMD_WRITE, CMD_READ: begin
                            if (r_cpuHold) begin
                                w_stateNext = ST_ADDR_H;
                                w_replyLoad = 1'b0;
                            end else begin
                                w_errNext   = 1'b1;
                                w_replyCode = RPL_ERR;
                            end
                        end
                        CMD_HOLD: w_holdSet = 1'b1;
                        CMD_GO:   w_holdClr = 1'b1;
                        default: begin
                            w_errNext   = 1'b1;
                            w_replyCode = RPL_ERR;
                        end
                    endcase
                end
            end
            ST_ADDR_H: begin
                if (bus.rx_valid)  w_stateNext = ST_ADDR_L;
                else if (w_expire) begin w_stateNext = ST_IDLE; w_errNext = 1'b1; end
            end
            ST_ADDR_L: begin
                if (bus.rx_valid)  w_stateNext = ST_LEN;
                else if (w_expire) begin w_stateNext = ST_IDLE; w_errNext = 1'b1; end
            end
            ST_LEN: begin
                if (bus.rx_valid)  w_stateNext = r_isWrite ? ST_DATA : ST_RD;
                else if (w_expire) begin w_stateNext = ST_IDLE; w_errNext = 1'b1; end
            end
            ST_DATA: begin
                if (bus.rx_valid)  w_stateNext = ST_WR;
                else if (w_expire) begin w_stateNext = ST_IDLE; w_errNext = 1'b1; end
            end
            ST_WR: begin
                if (bus.mem_ack) begin
                    if (r_count == 9'd1) begin
                        w_stateNext = ST_REPLY;
                        w_replyLoad = 1'b1;
                    end else begin
                        w_stateNext = ST_DATA;
                    end
                end
            end
            ST_RD: begin
                if (bus.mem_ack) w_stateNext = ST_RSEND;
            end
            ST_RSEND: begin
                if (bus.tx_ready) w_stateNext = (r_count == 9'd1) ? ST_IDLE : ST_RD;
            end
            ST_REPLY: begin
                if (bus.tx_ready) w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
        if (bus.rx_valid && ((r_state == ST_WR) || (r_state == ST_RD) ||
                             (r_state == ST_RSEND) || (r_state == ST_REPLY))) begin
            w_errNext = 1'b1;
        end
    end

    always_comb begin
        bus.mem_req  = (r_state == ST_WR) || (r_state == ST_RD);
        bus.mem_we   = (r_state == ST_WR);
        bus.tx_valid = (r_state == ST_RSEND) || (r_state == ST_REPLY);
        busy         = (r_state != ST_IDLE);
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.tx_data   = r_txData;
    assign cpu_hold      = r_cpuHold;
    assign err           = r_err;

    // Address and count advance only when a memory or transmit handshake completes.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_isWrite <= 1'b0;
            r_addr    <= 16'h0000;
            r_count   <= 9'd0;
            r_wdata   <= 8'h00;
            r_txData  <= 8'h00;
            r_err     <= 1'b0;
            r_cpuHold <= HOLD_ON_RESET;
        end else begin
            r_err <= w_errNext;
            if (w_holdSet)   r_cpuHold <= 1'b1;
            if (w_holdClr)   r_cpuHold <= 1'b0;
            if (w_replyLoad) r_txData  <= w_replyCode;
            case (r_state)
                ST_IDLE:   if (bus.rx_valid) r_isWrite <= (bus.rx_data == CMD_WRITE);
                ST_ADDR_H: if (bus.rx_valid) r_addr[15:8] <= bus.rx_data;
                ST_ADDR_L: if (bus.rx_valid) r_addr[7:0]  <= bus.rx_data;
                ST_LEN:    if (bus.rx_valid) r_count <= lenToCount(bus.rx_data);
                ST_DATA:   if (bus.rx_valid) r_wdata <= bus.rx_data;
                ST_WR: begin
                    if (bus.mem_ack) begin
                        r_addr  <= r_addr + 16'd1;
                        r_count <= r_count - 9'd1;
                    end
                end
                ST_RD:     if (bus.mem_ack) r_txData <= bus.mem_rdata;
                ST_RSEND: begin
                    if (bus.tx_ready) begin
                        r_addr  <= r_addr + 16'd1;
                        r_count <= r_count - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: RAM and UART-transmit models check
// each write, read address and transmitted byte against queued expectations.
module tb_uart_mem_loader;

    localparam int TIMEOUT = 100;
    localparam int GAP     = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk25 = 1'b0;
    logic rst;
    logic cpu_hold;
    logic busy;
    logic err;

    uart_mem_loader_if bus();

    uart_mem_loader #(
        .TIMEOUT_CYC  (TIMEOUT),
        .HOLD_ON_RESET(1'b1)
    ) dut (
        .clk25   (clk25),
        .rst     (rst),
        .bus     (bus),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .err     (err)
    );

    always #20 clk25 = ~clk25;

    wr_t         expWr[$];
    logic [15:0] expRdAddr[$];
    logic [7:0]  expTx[$];
    logic [7:0]  memModel [0:65535];

    int assertCount = 0;
    int failCount   = 0;
    int errSeen     = 0;
    int reqCycles   = 0;
    int ackDelay    = 0;
    int txStall     = 0;
    int memWait     = 0;
    int txWait      = 0;
    wr_t         wrCur;
    logic [15:0] rdCur;
    logic [7:0]  txCur;

    // RAM model: acks after ackDelay cycles of mem_req, checking every access.
    always @(negedge clk25) begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req === 1'b1) begin
            if (memWait < ackDelay) begin
                memWait++;
            end else begin
                memWait = 0;
                bus.mem_ack = 1'b1;
                assertCount++;
                if (bus.mem_we === 1'b1) begin
                    if (expWr.size() == 0) begin
                        failCount++;
                        $display("[TB] FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
                    end else begin
                        wrCur = expWr.pop_front();
                        if ({bus.mem_addr, bus.mem_wdata} !== {wrCur.addr, wrCur.data}) begin
                            failCount++;
                            $display("[TB] FAIL write got %h=%h expected %h=%h",
                                     bus.mem_addr, bus.mem_wdata, wrCur.addr, wrCur.data);
                        end
                    end
                    memModel[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    if (expRdAddr.size() == 0) begin
                        failCount++;
                        $display("[TB] FAIL unexpected_read addr=%h", bus.mem_addr);
                    end else begin
                        rdCur = expRdAddr.pop_front();
                        if (bus.mem_addr !== rdCur) begin
                            failCount++;
                            $display("[TB] FAIL read_addr got %h expected %h", bus.mem_addr, rdCur);
                        end
                    end
                    bus.mem_rdata = memModel[bus.mem_addr];
                end
            end
        end else begin
            memWait = 0;
        end
    end

    // UART transmitter model: stalls txStall cycles, then takes and checks the byte.
    always @(negedge clk25) begin
        bus.tx_ready = 1'b0;
        if (bus.tx_valid === 1'b1) begin
            if (txWait < txStall) begin
                txWait++;
            end else begin
                txWait = 0;
                bus.tx_ready = 1'b1;
                assertCount++;
                if (expTx.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL unexpected_tx byte=%h", bus.tx_data);
                end else begin
                    txCur = expTx.pop_front();
                    if (bus.tx_data !== txCur) begin
                        failCount++;
                        $display("[TB] FAIL tx_byte got %h expected %h", bus.tx_data, txCur);
                    end
                end
            end
        end else begin
            txWait = 0;
        end
    end

    always @(negedge clk25) begin
        if (err === 1'b1) errSeen++;
        if (bus.mem_req === 1'b1) reqCycles++;
    end

    initial begin
        #(40 * 60000);
        $display("[TB] FAIL watchdog expired, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk25);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk25);
        bus.rx_valid = 1'b0;
        repeat (GAP) @(negedge clk25);
    endtask

    task automatic waitIdle(input int maxCyc, input string name);
        int n = 0;
        while (((busy !== 1'b0) || (expTx.size() != 0)) && (n < maxCyc)) begin
            @(negedge clk25);
            n++;
        end
        assertCount++;
        if ((busy !== 1'b0) || (expTx.size() != 0)) begin
            failCount++;
            $display("[TB] FAIL %s_idle got busy=%b txPending=%0d expected busy=0 txPending=0",
                     name, busy, expTx.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk25);
        assertCount++;
        if ({cpu_hold, busy, err, bus.tx_valid, bus.mem_req, bus.mem_we} !== 6'b100000) begin
            failCount++;
            $display("[TB] FAIL reset_flags got hold,busy,err,txv,req,we=%b expected 100000",
                     {cpu_hold, busy, err, bus.tx_valid, bus.mem_req, bus.mem_we});
        end
        assertCount++;
        if ({bus.mem_addr, bus.mem_wdata, bus.tx_data} !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_data got addr=%h wdata=%h tx=%h expected zeros",
                     bus.mem_addr, bus.mem_wdata, bus.tx_data);
        end
        rst = 1'b0;
        @(negedge clk25);
    endtask

    task automatic test_go();
        int e0 = errSeen;
        expTx.push_back(8'h4B);
        applyStimulus(8'h47);
        waitIdle(50, "go");
        assertCount++;
        if (cpu_hold !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL go_hold got %b expected 0", cpu_hold);
        end
        assertCount++;
        if (errSeen != e0) begin
            failCount++;
            $display("[TB] FAIL go_err got %0d expected %0d", errSeen, e0);
        end
    endtask

    task automatic test_illegal();
        int e0 = errSeen;
        int r0 = reqCycles;
        expTx.push_back(8'h3F);
        applyStimulus(8'h57);
        waitIdle(50, "w_unheld");
        expTx.push_back(8'h3F);
        applyStimulus(8'h99);
        waitIdle(50, "unknown");
        assertCount++;
        if (errSeen != e0 + 2) begin
            failCount++;
            $display("[TB] FAIL illegal_err got %0d expected %0d", errSeen, e0 + 2);
        end
        assertCount++;
        if (reqCycles != r0) begin
            failCount++;
            $display("[TB] FAIL illegal_req got %0d expected %0d", reqCycles, r0);
        end
    endtask

    task automatic test_hold();
        expTx.push_back(8'h4B);
        applyStimulus(8'h48);
        waitIdle(50, "hold");
        assertCount++;
        if (cpu_hold !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL hold_set got %b expected 1", cpu_hold);
        end
    endtask

    task automatic test_write(input int delay);
        logic [7:0] frame [7] = '{8'h57, 8'h12, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        int e0 = errSeen;
        ackDelay = delay;
        memModel[16'h1234] = 8'h00;
        memModel[16'h1235] = 8'h00;
        memModel[16'h1236] = 8'h00;
        expWr.push_back('{16'h1234, 8'hAA});
        expWr.push_back('{16'h1235, 8'hBB});
        expWr.push_back('{16'h1236, 8'hCC});
        expTx.push_back(8'h4B);
        for (int i = 0; i < 7; i++) applyStimulus(frame[i]);
        waitIdle(100, "write");
        assertCount++;
        if (expWr.size() != 0) begin
            failCount++;
            $display("[TB] FAIL write_count got %0d missing expected 0 (delay %0d)", expWr.size(), delay);
        end
        assertCount++;
        if ({memModel[16'h1234], memModel[16'h1235], memModel[16'h1236]} !== 24'hAABBCC) begin
            failCount++;
            $display("[TB] FAIL write_mem got %h%h%h expected aabbcc",
                     memModel[16'h1234], memModel[16'h1235], memModel[16'h1236]);
        end
        assertCount++;
        if (errSeen != e0) begin
            failCount++;
            $display("[TB] FAIL write_err got %0d expected %0d", errSeen, e0);
        end
    endtask

    task automatic test_read_wrap();
        int e0 = errSeen;
        ackDelay = 1;
        txStall  = 5;
        memModel[16'hFFFF] = 8'h11;
        memModel[16'h0000] = 8'h22;
        expRdAddr.push_back(16'hFFFF);
        expRdAddr.push_back(16'h0000);
        expTx.push_back(8'h11);
        expTx.push_back(8'h22);
        applyStimulus(8'h52);
        applyStimulus(8'hFF);
        applyStimulus(8'hFF);
        applyStimulus(8'h02);
        waitIdle(200, "read_wrap");
        txStall = 0;
        assertCount++;
        if (expRdAddr.size() != 0) begin
            failCount++;
            $display("[TB] FAIL read_count got %0d missing expected 0", expRdAddr.size());
        end
        assertCount++;
        if (bus.mem_addr !== 16'h0001) begin
            failCount++;
            $display("[TB] FAIL read_final_addr got %h expected 0001", bus.mem_addr);
        end
        assertCount++;
        if (errSeen != e0) begin
            failCount++;
            $display("[TB] FAIL read_err got %0d expected %0d", errSeen, e0);
        end
    endtask

    task automatic test_drop();
        int e0 = errSeen;
        ackDelay = 0;
        txStall  = 20;
        memModel[16'h0500] = 8'h5C;
        expRdAddr.push_back(16'h0500);
        expTx.push_back(8'h5C);
        applyStimulus(8'h52);
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'hEE);
        waitIdle(100, "drop");
        txStall = 0;
        assertCount++;
        if (errSeen != e0 + 1) begin
            failCount++;
            $display("[TB] FAIL drop_err got %0d expected %0d", errSeen, e0 + 1);
        end
    endtask

    task automatic test_len256();
        ackDelay = 0;
        for (int i = 0; i < 256; i++) expWr.push_back('{16'(i), 8'(i) ^ 8'h5A});
        expTx.push_back(8'h4B);
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        for (int i = 0; i < 256; i++) applyStimulus(8'(i) ^ 8'h5A);
        waitIdle(100, "len256");
        assertCount++;
        if (expWr.size() != 0) begin
            failCount++;
            $display("[TB] FAIL len256_count got %0d missing expected 0", expWr.size());
        end
        assertCount++;
        if (bus.mem_addr !== 16'h0100) begin
            failCount++;
            $display("[TB] FAIL len256_addr got %h expected 0100", bus.mem_addr);
        end
    endtask

    task automatic test_timeout();
        int e0 = errSeen;
        int n  = 0;
        applyStimulus(8'h57);
        applyStimulus(8'h10);
        while ((err !== 1'b1) && (n < 150)) begin
            @(negedge clk25);
            n++;
        end
        assertCount++;
        if ((n < 90) || (n > 105)) begin
            failCount++;
            $display("[TB] FAIL timeout_cycles got %0d expected 90..105", n);
        end
        @(negedge clk25);
        assertCount++;
        if ((busy !== 1'b0) || (errSeen != e0 + 1)) begin
            failCount++;
            $display("[TB] FAIL timeout_abort got busy=%b errs=%0d expected busy=0 errs=%0d",
                     busy, errSeen, e0 + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ackDelay = 100000;
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h40);
        applyStimulus(8'h01);
        @(negedge clk25);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        @(negedge clk25);
        bus.rx_valid = 1'b0;
        while ((bus.mem_req !== 1'b1) && (n < 10)) begin
            @(negedge clk25);
            n++;
        end
        assertCount++;
        if (bus.mem_req !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midreset_req_up got %b expected 1", bus.mem_req);
        end
        rst = 1'b1;
        #1;
        assertCount++;
        if ({bus.mem_req, bus.mem_we, busy, bus.tx_valid, cpu_hold} !== 5'b00001) begin
            failCount++;
            $display("[TB] FAIL midreset_outputs got req,we,busy,txv,hold=%b expected 00001",
                     {bus.mem_req, bus.mem_we, busy, bus.tx_valid, cpu_hold});
        end
        @(negedge clk25);
        rst = 1'b0;
        ackDelay = 0;
        @(negedge clk25);
    endtask

    initial begin
        test_reset();
        test_go();
        test_illegal();
        test_hold();
        test_write(1);
        test_write(0);
        test_read_wrap();
        test_drop();
        test_len256();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
